// File: rtl/ex05_logic_if.sv
// Operand/result bundle for the ex05_logic Boolean unit.
// The master drives the three operand bits and the slave returns x, y, z.
interface ex05_logic_if;
    logic a;
    logic b;
    logic c;
    logic x;
    logic y;
    logic z;

    modport master (output a, b, c, input  x, y, z);
    modport slave  (input  a, b, c, output x, y, z);
endinterface

// File: rtl/ex05_logic.sv
// Three-input Boolean unit: majority (carry), odd parity (sum) and all-equal flag.
// The outputs are either registered with one cycle of latency or purely combinational.
module ex05_logic #(
    parameter bit         OUT_REG   = 1'b1,
    parameter logic [2:0] RESET_VAL = 3'b000
) (
    input  logic         clk,
    input  logic         rst_n,
    ex05_logic_if.slave  bus
);

    logic [2:0] xyz_d;

    always_comb begin
        xyz_d    = '0;
        xyz_d[2] = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
        xyz_d[1] = bus.a ^ bus.b ^ bus.c;
        xyz_d[0] = (bus.a & bus.b & bus.c) | (~bus.a & ~bus.b & ~bus.c);
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [2:0] xyz_q;

            // No enable: a fresh code is captured on every edge, and reset drops any in-flight result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) xyz_q <= RESET_VAL;
                else        xyz_q <= xyz_d;
            end

            assign bus.x = xyz_q[2];
            assign bus.y = xyz_q[1];
            assign bus.z = xyz_q[0];
        end else begin : g_comb
            // Clock and reset have no function in this build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign bus.x = xyz_d[2];
            assign bus.y = xyz_d[1];
            assign bus.z = xyz_d[0];
        end
    endgenerate

endmodule

// File: tb/tb_ex05_logic.sv
// Directed and random checks of ex05_logic in both registered and combinational builds.
// Expected values come from the hand-written truth table below.
module tb_ex05_logic;

    logic clk;
    logic rst_n;
    logic clk_off;
    logic rst_off;

    int n_chk;
    int n_err;

    logic [2:0] exp_tab [8];

    ex05_logic_if bus_r ();
    ex05_logic_if bus_c ();

    ex05_logic #(.OUT_REG(1'b1), .RESET_VAL(3'b000)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r.slave)
    );

    ex05_logic #(.OUT_REG(1'b0), .RESET_VAL(3'b000)) u_comb (
        .clk   (clk_off),
        .rst_n (rst_off),
        .bus   (bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %b want %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_r(input logic [2:0] abc);
        bus_r.a = abc[2];
        bus_r.b = abc[1];
        bus_r.c = abc[0];
    endtask

    task automatic drive_c(input logic [2:0] abc);
        bus_c.a = abc[2];
        bus_c.b = abc[1];
        bus_c.c = abc[0];
    endtask

    function automatic logic [2:0] xyz_r();
        return {bus_r.x, bus_r.y, bus_r.z};
    endfunction

    function automatic logic [2:0] xyz_c();
        return {bus_c.x, bus_c.y, bus_c.z};
    endfunction

    initial begin
        logic [2:0] prev;
        logic [2:0] cur;
        logic [2:0] o;

        n_chk   = 0;
        n_err   = 0;
        clk_off = 1'b0;
        rst_off = 1'b0;
        exp_tab[0] = 3'b001; exp_tab[1] = 3'b010; exp_tab[2] = 3'b010; exp_tab[3] = 3'b100;
        exp_tab[4] = 3'b010; exp_tab[5] = 3'b100; exp_tab[6] = 3'b100; exp_tab[7] = 3'b111;

        // Reset held while inputs change freely, across several clock edges.
        rst_n = 1'b1;
        drive_r(3'b111);
        drive_c(3'b000);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_r(3'(i + 3));
            #3 chk("rst_hold", xyz_r(), 3'b000);
        end

        // Release with 000 applied: first edge loads 001.
        @(negedge clk);
        rst_n = 1'b1;
        drive_r(3'b000);
        @(posedge clk); #1;
        chk("rst_rel", xyz_r(), 3'b001);

        // Sweep all codes, one per clock.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_r(3'(i));
            @(posedge clk); #1;
            chk("sweep", xyz_r(), exp_tab[i]);
        end

        // Latency: a between-edge change is invisible until the next edge.
        @(negedge clk);
        drive_r(3'b011);
        @(posedge clk); #1;
        chk("lat_011", xyz_r(), 3'b100);
        #1 drive_r(3'b100);
        #1 chk("lat_hold", xyz_r(), 3'b100);
        @(posedge clk); #1;
        chk("lat_100", xyz_r(), 3'b010);

        // Asynchronous reset pulse between edges with 111 applied.
        @(negedge clk);
        drive_r(3'b111);
        @(posedge clk); #1;
        chk("pre_arst", xyz_r(), 3'b111);
        #1 rst_n = 1'b0;
        #1 chk("arst", xyz_r(), 3'b000);
        #1 rst_n = 1'b1;
        #1 chk("arst_rel", xyz_r(), 3'b000);
        @(posedge clk); #1;
        chk("post_arst", xyz_r(), 3'b111);

        // Combinational build, its clock never toggles and its reset is held low.
        drive_c(3'b101);
        #1 chk("comb_101", xyz_c(), 3'b100);
        drive_c(3'b000);
        #1 chk("comb_000", xyz_c(), 3'b001);
        for (int i = 0; i < 8; i++) begin
            drive_c(3'(i));
            #1 chk("comb_sweep", xyz_c(), exp_tab[i]);
        end

        // Random run: one-cycle-delayed reference plus output invariants.
        @(negedge clk);
        prev = 3'($urandom_range(0, 7));
        drive_r(prev);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            o = xyz_r();
            chk("rand", o, exp_tab[prev]);
            chk("inv_z", {2'b00, (o[0] & (o[2] != o[1]))}, 3'b000);
            chk("inv_11", {2'b00, (o[2] & o[1] & (prev != 3'b111))}, 3'b000);
            chk("inv_00", {2'b00, (~o[2] & ~o[1] & (prev != 3'b000))}, 3'b000);
            @(negedge clk);
            cur = 3'($urandom_range(0, 7));
            drive_r(cur);
            prev = cur;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ex05_logic.md
Name: ex05_logic

Overview:
- Three-input, three-output Boolean function unit with registered outputs.
- Treats inputs a, b, c as one 3-bit vector and produces:
  - x: majority vote, equivalent to full-adder carry.
  - y: odd parity, equivalent to full-adder sum.
  - z: all-inputs-equal flag.
- Used as a small combinational/registered building block and exercise module.
- The bench sweeps all 8 input codes and prints the outputs.

Parameters:
- OUT_REG, default 1: 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational and clock/reset ignored.
- RESET_VAL, default 3'b000: value of {x,y,z} while reset is asserted (OUT_REG=1 only).

Ports:
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  operand bit, MSB of input code.
- b  input  1  operand bit.
- c  input  1  operand bit, LSB of input code.
- x  output  1  majority of a, b, c.
- y  output  1  parity a XOR b XOR c.
- z  output  1  1 when a, b and c are all equal.

Behaviour:
- Combinational functions:
  - x_n = (a&b) | (a&c) | (b&c).
  - y_n = a ^ b ^ c.
  - z_n = (a&b&c) | (~a&~b&~c).
- Truth table, abc -> xyz:
  - 000 -> 001
  - 001 -> 010
  - 010 -> 010
  - 011 -> 100
  - 100 -> 010
  - 101 -> 100
  - 110 -> 100
  - 111 -> 111
- OUT_REG=1 (default):
  - {x,y,z} <= {x_n,y_n,z_n} on every rising clk edge. Latency is exactly 1 cycle.
  - No enable: a new input code is sampled every cycle.
  - rst_n low forces {x,y,z} = RESET_VAL immediately, without waiting for a clock edge. Outputs hold that value for as long as rst_n is low.
  - First update after reset: the first rising clk edge with rst_n high loads the function of the inputs sampled at that edge.
  - Reset mid-operation: outputs drop to RESET_VAL asynchronously and the in-flight result is discarded.
- OUT_REG=0:
  - Outputs follow the inputs combinationally with zero latency.
  - clk and rst_n have no effect.
- Input handling:
  - Inputs are sampled without synchronisers. The driver meets setup/hold relative to clk.
  - X/Z on an input propagates per standard Verilog semantics; no masking is required.
- Invariants, checkable every cycle:
  - z=1 implies x==y.
  - x=1 and y=1 occurs only for code 111.
  - x=0 and y=0 occurs only for code 000.

Test Plan:
- Reset: hold rst_n=0 and toggle a/b/c freely -> {x,y,z}=000 at all times. Release rst_n; next edge with abc=000 -> xyz=001.
- Exhaustive sweep, OUT_REG=1: step abc through 000..111, one code per clock (c toggles each cycle, b every 2, a every 4) -> one cycle later xyz follows the table: 001, 010, 010, 100, 010, 100, 100, 111.
- Latency check: change abc from 011 to 100 between edges -> xyz stays 100 until the next edge, then becomes 010.
- Asynchronous reset mid-run: with abc=111 and xyz=111, pulse rst_n low between clock edges -> xyz becomes 000 before the next edge. After release, xyz=111 on the following edge.
- OUT_REG=0 build, no clock running: apply abc=101 -> xyz=100 after a delta. Apply abc=000 -> xyz=001.
- Invariants: over random abc for 1000 cycles, assert z implies x==y, and the registered outputs match a reference model delayed by one cycle.
